// File: rtl/hp_fifo_pkg.sv
// Shared constants and Gray-code helpers for the host->parasite FIFO.
// Pointers are handled at the widest legal width and then narrowed to PTR_W.
package hp_fifo_pkg;

   localparam int MAX_PTR_W = 5;

   typedef logic [MAX_PTR_W-1:0] ptr_t;

   function automatic int fifo_depth(input int dl2);
      return 1 << dl2;
   endfunction

   function automatic int fifo_ptr_w(input int dl2);
      return dl2 + 1;
   endfunction

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   // Zero-extended narrow pointers convert correctly: the extra high bits stay 0.
   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b = '0;
      b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
      for (int i = MAX_PTR_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

endpackage

// File: rtl/hp_sync_m.sv
// Falling-edge multi-flop synchroniser for a Gray-coded pointer bus.
module hp_sync_m #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] pipe;

   always_ff @(negedge clk or negedge rst_b) begin
      if (!rst_b) pipe <= '0;
      else        pipe <= {pipe[STAGES-2:0], d};
   end

   assign q = pipe[STAGES-1];

endmodule

// File: rtl/hp_fifo_n.sv
// Asynchronous host-to-parasite FIFO: host writes on h_phi2 fall, parasite reads
// on p_phi2 fall, pointers cross as registered Gray code, first-word fall-through.
module hp_fifo_n
   import hp_fifo_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DEPTH_LOG2  = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  h_rst_b,
   input  logic                  h_phi2,
   input  logic                  p_phi2,
   input  logic                  h_selectData,
   input  logic                  h_we_b,
   input  logic [WIDTH-1:0]      h_data,
   input  logic                  p_selectData,
   input  logic                  p_rdnw,
   input  logic                  p_two_byte,
   output logic [WIDTH-1:0]      p_data,
   output logic                  p_data_available,
   output logic                  h_full,
   output logic [DEPTH_LOG2:0]   p_count
);

   localparam int DEPTH = fifo_depth(DEPTH_LOG2);
   localparam int PTR_W = fifo_ptr_w(DEPTH_LOG2);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wptr, wptr_nxt, wgray, wgray_s, wptr_s;
   logic [PTR_W-1:0] rptr, rptr_nxt, rgray, rgray_s, rptr_s;
   logic             h_wr, p_rd;

   assign wptr_nxt = wptr + PTR_W'(1);
   assign rptr_nxt = rptr + PTR_W'(1);

   // ---------------- host domain ----------------
   assign h_wr = h_selectData & ~h_we_b & ~h_full;

   always_ff @(negedge h_phi2 or negedge h_rst_b) begin
      if (!h_rst_b) begin
         wptr  <= '0;
         wgray <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (h_wr) begin
         mem[wptr[DEPTH_LOG2-1:0]] <= h_data;
         wptr  <= wptr_nxt;
         wgray <= PTR_W'(bin2gray(ptr_t'(wptr_nxt)));
      end
   end

   hp_sync_m #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_rsync (
      .clk   (h_phi2),
      .rst_b (h_rst_b),
      .d     (rgray),
      .q     (rgray_s)
   );

   assign rptr_s = PTR_W'(gray2bin(ptr_t'(rgray_s)));
   // A stale rptr_s can only overstate occupancy, so full is never falsely clear.
   assign h_full = ((wptr - rptr_s) == PTR_W'(DEPTH));

   // ---------------- parasite domain ----------------
   hp_sync_m #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_wsync (
      .clk   (p_phi2),
      .rst_b (h_rst_b),
      .d     (wgray),
      .q     (wgray_s)
   );

   assign wptr_s  = PTR_W'(gray2bin(ptr_t'(wgray_s)));
   assign p_count = wptr_s - rptr;
   assign p_rd    = p_selectData & p_rdnw & (p_count != '0);

   always_ff @(negedge p_phi2 or negedge h_rst_b) begin
      if (!h_rst_b) begin
         rptr  <= '0;
         rgray <= '0;
      end else if (p_rd) begin
         rptr  <= rptr_nxt;
         rgray <= PTR_W'(bin2gray(ptr_t'(rptr_nxt)));
      end
   end

   assign p_data           = mem[rptr[DEPTH_LOG2-1:0]];
   assign p_data_available = p_two_byte ? (p_count >= PTR_W'(2)) : (p_count != '0);

endmodule

// File: tb/tb_hp_fifo_n.sv
// Bench for hp_fifo_n: directed literal checks on a 2-deep instance and a
// queue-model randomized run on a 4-deep instance at 2 MHz host / 3.7 MHz parasite.
`timescale 1ns/100ps
module tb_hp_fifo_n;

   logic h_phi2, p_phi2, rst_b;

   // instance A: DEPTH_LOG2=1
   logic       a_hsel, a_hwe_b, a_psel, a_rdnw, a_two;
   logic [7:0] a_hdata, a_pdata;
   logic       a_dav, a_full;
   logic [1:0] a_cnt;

   // instance B: DEPTH_LOG2=2
   logic       b_hsel, b_hwe_b, b_psel, b_rdnw, b_two;
   logic [7:0] b_hdata, b_pdata;
   logic       b_dav, b_full;
   logic [2:0] b_cnt;

   int vecs = 0;
   int errs = 0;
   logic [7:0] q[$];
   int stale = 0;

   hp_fifo_n #(.WIDTH(8), .DEPTH_LOG2(1), .SYNC_STAGES(2)) u_dut_a (
      .h_rst_b(rst_b), .h_phi2(h_phi2), .p_phi2(p_phi2),
      .h_selectData(a_hsel), .h_we_b(a_hwe_b), .h_data(a_hdata),
      .p_selectData(a_psel), .p_rdnw(a_rdnw), .p_two_byte(a_two),
      .p_data(a_pdata), .p_data_available(a_dav), .h_full(a_full), .p_count(a_cnt)
   );

   hp_fifo_n #(.WIDTH(8), .DEPTH_LOG2(2), .SYNC_STAGES(2)) u_dut_b (
      .h_rst_b(rst_b), .h_phi2(h_phi2), .p_phi2(p_phi2),
      .h_selectData(b_hsel), .h_we_b(b_hwe_b), .h_data(b_hdata),
      .p_selectData(b_psel), .p_rdnw(b_rdnw), .p_two_byte(b_two),
      .p_data(b_pdata), .p_data_available(b_dav), .h_full(b_full), .p_count(b_cnt)
   );

   // 2 MHz host, ~3.7 MHz parasite; the fractional offset keeps edges apart
   initial begin
      h_phi2 = 1'b1;
      forever #250 h_phi2 = ~h_phi2;
   end
   initial begin
      p_phi2 = 1'b1;
      #37.3;
      forever #135 p_phi2 = ~p_phi2;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic a_wr(input logic [7:0] d);
      @(posedge h_phi2); a_hsel = 1'b1; a_hwe_b = 1'b0; a_hdata = d;
      @(negedge h_phi2); #1; a_hsel = 1'b0; a_hwe_b = 1'b1;
   endtask

   task automatic a_rd();
      @(posedge p_phi2); a_psel = 1'b1;
      @(negedge p_phi2); #1; a_psel = 1'b0;
   endtask

   task automatic pwait(input int n);
      repeat (n) @(negedge p_phi2);
      #1;
   endtask

   task automatic hwait(input int n);
      repeat (n) @(negedge h_phi2);
      #1;
   endtask

   // Host side of instance B: writes when not full, checks full is conservative.
   task automatic b_host(input int n, input logic [7:0] base, input bit incr);
      int sent = 0;
      int cyc  = 0;
      logic [7:0] d;
      while (sent < n && cyc < 4000) begin
         @(posedge h_phi2); cyc++;
         b_hsel = 1'b0; b_hwe_b = 1'b1;
         chk("b_full_false_clear", 32'(!b_full && q.size() >= 4), 32'(0));
         if (b_full && q.size() < 4) stale++; else stale = 0;
         chk("b_full_stale", 32'(stale > 5), 32'(0));
         if (!b_full && $urandom_range(0, 3) != 0) begin
            d = incr ? 8'(int'(base) + sent) : 8'($urandom);
            b_hsel = 1'b1; b_hwe_b = 1'b0; b_hdata = d;
            q.push_back(d);
            sent++;
         end
      end
      @(posedge h_phi2); b_hsel = 1'b0; b_hwe_b = 1'b1;
      chk("b_host_sent", 32'(sent), 32'(n));
   endtask

   // Parasite side of instance B: compares outputs against the queue every cycle.
   task automatic b_para(input int n, input logic [7:0] base, input bit incr);
      int got = 0;
      int cyc = 0;
      while (got < n && cyc < 8000) begin
         @(posedge p_phi2); cyc++;
         b_psel = 1'b0;
         chk("b_cnt_conservative", 32'(int'(b_cnt) > q.size()), 32'(0));
         chk("b_dav", 32'(b_dav), 32'(b_two ? (b_cnt >= 3'd2) : (b_cnt >= 3'd1)));
         if (b_cnt != 3'd0 && q.size() > 0) begin
            chk("b_data", 32'(b_pdata), 32'(q[0]));
            if ($urandom_range(0, 2) != 0) begin
               if (incr) chk("b_seq", 32'(b_pdata), 32'(8'(int'(base) + got)));
               b_psel = 1'b1; b_rdnw = 1'b1;
               void'(q.pop_front());
               got++;
            end
         end
      end
      @(posedge p_phi2); b_psel = 1'b0;
      chk("b_para_got", 32'(got), 32'(n));
   endtask

   initial begin
      rst_b = 1'b0;
      {a_hsel, a_psel, a_two, b_hsel, b_psel, b_two} = '0;
      a_hwe_b = 1'b1; b_hwe_b = 1'b1; a_rdnw = 1'b1; b_rdnw = 1'b1;
      a_hdata = '0; b_hdata = '0;
      #1010;
      chk("rst_a_pdata", 32'(a_pdata), 32'(0));
      chk("rst_a_dav",   32'(a_dav),   32'(0));
      chk("rst_a_full",  32'(a_full),  32'(0));
      chk("rst_a_cnt",   32'(a_cnt),   32'(0));
      chk("rst_b_pdata", 32'(b_pdata), 32'(0));
      chk("rst_b_cnt",   32'(b_cnt),   32'(0));
      chk("rst_b_full",  32'(b_full),  32'(0));
      chk("rst_b_dav",   32'(b_dav),   32'(0));
      @(posedge h_phi2); #20; rst_b = 1'b1;

      // single write falls through within three parasite edges
      a_wr(8'hA5); pwait(3);
      chk("a5_dav",  32'(a_dav),   32'(1));
      chk("a5_data", 32'(a_pdata), 32'(8'hA5));
      chk("a5_cnt",  32'(a_cnt),   32'(1));
      a_rd(); #1;
      chk("a5_rd_cnt", 32'(a_cnt), 32'(0));
      chk("a5_rd_dav", 32'(a_dav), 32'(0));
      hwait(4);

      // fill to 2, overflow write dropped
      a_wr(8'h11);
      chk("fill1_full", 32'(a_full), 32'(0));
      a_wr(8'h22);
      chk("fill2_full", 32'(a_full), 32'(1));
      a_wr(8'h33);
      chk("ovf_full", 32'(a_full), 32'(1));
      pwait(3);
      chk("ovf_cnt",  32'(a_cnt),   32'(2));
      chk("ovf_rd0",  32'(a_pdata), 32'(8'h11));
      a_rd(); #1;
      chk("ovf_rd1",  32'(a_pdata), 32'(8'h22));
      chk("ovf_cnt1", 32'(a_cnt),   32'(1));
      hwait(3);
      chk("full_clear", 32'(a_full), 32'(0));
      a_rd(); #1;
      chk("ovf_cnt0", 32'(a_cnt), 32'(0));
      chk("ovf_dav0", 32'(a_dav), 32'(0));
      hwait(4);

      // two-byte mode
      a_two = 1'b1;
      a_wr(8'h01); pwait(3);
      chk("two_dav1", 32'(a_dav), 32'(0));
      chk("two_cnt1", 32'(a_cnt), 32'(1));
      a_wr(8'h02); pwait(3);
      chk("two_dav2",  32'(a_dav),   32'(1));
      chk("two_cnt2",  32'(a_cnt),   32'(2));
      chk("two_data",  32'(a_pdata), 32'(8'h01));
      a_two = 1'b0; #1;
      chk("mode_dav_a", 32'(a_dav), 32'(1));
      a_rd(); #1;
      chk("mode_data", 32'(a_pdata), 32'(8'h02));
      a_two = 1'b1; #1;
      chk("mode_dav_b", 32'(a_dav), 32'(0));
      a_two = 1'b0; #1;
      chk("mode_dav_c", 32'(a_dav), 32'(1));
      a_rd(); #1;
      chk("mode_cnt0", 32'(a_cnt), 32'(0));
      hwait(4);

      // read on empty leaves rptr alone
      a_rd(); #1;
      chk("empty_cnt", 32'(a_cnt), 32'(0));
      chk("empty_dav", 32'(a_dav), 32'(0));
      pwait(2);
      a_wr(8'h77); pwait(3);
      chk("empty_cnt1", 32'(a_cnt),   32'(1));
      chk("empty_data", 32'(a_pdata), 32'(8'h77));
      a_rd(); hwait(4);

      // instance B: incrementing stream across pointer wrap, then random data
      b_two = 1'b0;
      fork
         b_host(40, 8'h30, 1'b1);
         b_para(40, 8'h30, 1'b1);
      join
      hwait(4);
      b_two = 1'b1;
      fork
         b_host(60, 8'h00, 1'b0);
         b_para(60, 8'h00, 1'b0);
      join
      pwait(4);
      chk("b_drained_cnt", 32'(b_cnt), 32'(0));
      chk("b_drained_q",   32'(q.size()), 32'(0));

      // reset mid-operation discards contents
      a_wr(8'h10); a_wr(8'h20); pwait(3);
      chk("pre_rst_cnt",  32'(a_cnt),  32'(2));
      chk("pre_rst_full", 32'(a_full), 32'(1));
      #20; rst_b = 1'b0; #100;
      chk("mid_rst_cnt",   32'(a_cnt),   32'(0));
      chk("mid_rst_full",  32'(a_full),  32'(0));
      chk("mid_rst_dav",   32'(a_dav),   32'(0));
      chk("mid_rst_pdata", 32'(a_pdata), 32'(0));
      @(posedge h_phi2); #20; rst_b = 1'b1;
      a_wr(8'h5A); pwait(3);
      chk("post_rst_data", 32'(a_pdata), 32'(8'h5A));
      chk("post_rst_cnt",  32'(a_cnt),   32'(1));
      chk("post_rst_dav",  32'(a_dav),   32'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
